// File: rtl/mod1_2.sv
// mod1_2: third radix-2 FFT stage, distance-8 butterflies on the add/sub groups, -j twiddle on sub-group difference
//
// Ports:
//   clk, rstn (async active-low)
//   alert_mod11          first-valid pulse from mod1_1
//   din_{R,Q}_add_1/2    add-group samples, DEPTH lanes of signed DIN_WIDTH
//   din_{R,Q}_sub_1/2    sub-group samples, DEPTH lanes of signed DIN_WIDTH
//   dout_{R,Q}_aa/as     add-group sum / difference, DEPTH lanes of signed DOUT_WIDTH
//   dout_{R,Q}_sa/ss     sub-group sum / (difference * -j), DEPTH lanes of signed DOUT_WIDTH
//   alert_mod12          first-valid pulse to the next stage, 2 cycles after alert_mod11
module mod1_2 #(
    parameter int DIN_WIDTH  = 15,
    parameter int DOUT_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int FRAME_LEN  = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 alert_mod11,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_R_add_1,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_R_add_2,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_R_sub_1,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_R_sub_2,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_Q_add_1,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_Q_add_2,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_Q_sub_1,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      din_Q_sub_2,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_aa,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_as,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_sa,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_ss,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_aa,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_as,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_sa,
    output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_ss,
    output logic                                 alert_mod12
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          active;
    logic          frame_end;
    logic          tag;

    logic [DEPTH-1:0][DOUT_WIDTH-1:0] n_aa_r, n_as_r, n_sa_r, n_d_r;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0] n_aa_q, n_as_q, n_sa_q, n_d_q;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0] aa_r, as_r, sa_r, d_r;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0] aa_q, as_q, sa_q, d_q;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0] neg_d_r;

    function automatic logic [DOUT_WIDTH-1:0] ext(input logic [DIN_WIDTH-1:0] x);
        return DOUT_WIDTH'($signed(x));
    endfunction

    // cnt holds the index of the current input cycle while in RUN; the alert
    // cycle itself is index 0, so RUN covers indices 1..FRAME_LEN-1 and the
    // frame has exactly FRAME_LEN active cycles.
    assign active    = alert_mod11 || state == RUN;
    assign frame_end = state == RUN && cnt == CW'(FRAME_LEN - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (alert_mod11) begin
            state <= RUN;
            cnt   <= CW'(1);
        end else if (frame_end) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Operands are sign-extended by one bit first, so sums and differences
    // cannot overflow and negating the widened difference never wraps.
    always_comb begin
        n_aa_r  = '0;
        n_as_r  = '0;
        n_sa_r  = '0;
        n_d_r   = '0;
        n_aa_q  = '0;
        n_as_q  = '0;
        n_sa_q  = '0;
        n_d_q   = '0;
        neg_d_r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            n_aa_r[k]  = ext(din_R_add_1[k]) + ext(din_R_add_2[k]);
            n_as_r[k]  = ext(din_R_add_1[k]) - ext(din_R_add_2[k]);
            n_sa_r[k]  = ext(din_R_sub_1[k]) + ext(din_R_sub_2[k]);
            n_d_r[k]   = ext(din_R_sub_1[k]) - ext(din_R_sub_2[k]);
            n_aa_q[k]  = ext(din_Q_add_1[k]) + ext(din_Q_add_2[k]);
            n_as_q[k]  = ext(din_Q_add_1[k]) - ext(din_Q_add_2[k]);
            n_sa_q[k]  = ext(din_Q_sub_1[k]) + ext(din_Q_sub_2[k]);
            n_d_q[k]   = ext(din_Q_sub_1[k]) - ext(din_Q_sub_2[k]);
            neg_d_r[k] = -d_r[k];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {aa_r, as_r, sa_r, d_r} <= '0;
            {aa_q, as_q, sa_q, d_q} <= '0;
            tag                     <= 1'b0;
        end else begin
            aa_r <= active ? n_aa_r : '0;
            as_r <= active ? n_as_r : '0;
            sa_r <= active ? n_sa_r : '0;
            d_r  <= active ? n_d_r  : '0;
            aa_q <= active ? n_aa_q : '0;
            as_q <= active ? n_as_q : '0;
            sa_q <= active ? n_sa_q : '0;
            d_q  <= active ? n_d_q  : '0;
            tag  <= alert_mod11;
        end
    end

    // Multiplying by -j: (dr + j*dq) * -j = dq - j*dr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {dout_R_aa, dout_R_as, dout_R_sa, dout_R_ss} <= '0;
            {dout_Q_aa, dout_Q_as, dout_Q_sa, dout_Q_ss} <= '0;
            alert_mod12                                  <= 1'b0;
        end else begin
            dout_R_aa   <= aa_r;
            dout_R_as   <= as_r;
            dout_R_sa   <= sa_r;
            dout_R_ss   <= d_q;
            dout_Q_aa   <= aa_q;
            dout_Q_as   <= as_q;
            dout_Q_sa   <= sa_q;
            dout_Q_ss   <= neg_d_r;
            alert_mod12 <= tag;
        end
    end
endmodule

// File: tb/tb_mod1_2.sv
// tb_mod1_2: directed self-checking bench for mod1_2
module tb_mod1_2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic alert_mod11 = 1'b0;
    logic [DEPTH-1:0][14:0] din_R_add_1, din_R_add_2, din_R_sub_1, din_R_sub_2;
    logic [DEPTH-1:0][14:0] din_Q_add_1, din_Q_add_2, din_Q_sub_1, din_Q_sub_2;
    logic [DEPTH-1:0][15:0] dout_R_aa, dout_R_as, dout_R_sa, dout_R_ss;
    logic [DEPTH-1:0][15:0] dout_Q_aa, dout_Q_as, dout_Q_sa, dout_Q_ss;
    logic alert_mod12;

    int total = 0;
    int bad = 0;
    logic [127:0] ev [8];
    string nm [8] = '{"R_aa", "R_as", "R_sa", "R_ss", "Q_aa", "Q_as", "Q_sa", "Q_ss"};

    mod1_2 dut (
        .clk(clk), .rstn(rstn), .alert_mod11(alert_mod11),
        .din_R_add_1(din_R_add_1), .din_R_add_2(din_R_add_2),
        .din_R_sub_1(din_R_sub_1), .din_R_sub_2(din_R_sub_2),
        .din_Q_add_1(din_Q_add_1), .din_Q_add_2(din_Q_add_2),
        .din_Q_sub_1(din_Q_sub_1), .din_Q_sub_2(din_Q_sub_2),
        .dout_R_aa(dout_R_aa), .dout_R_as(dout_R_as), .dout_R_sa(dout_R_sa), .dout_R_ss(dout_R_ss),
        .dout_Q_aa(dout_Q_aa), .dout_Q_as(dout_Q_as), .dout_Q_sa(dout_Q_sa), .dout_Q_ss(dout_Q_ss),
        .alert_mod12(alert_mod12)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rep(input int v);
        return {DEPTH{16'(v)}};
    endfunction

    task automatic chk_outs(input string tag, input bit act, input bit al);
        logic [127:0] o [8];
        o = '{dout_R_aa, dout_R_as, dout_R_sa, dout_R_ss, dout_Q_aa, dout_Q_as, dout_Q_sa, dout_Q_ss};
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s.%s", tag, nm[k]), o[k], act ? ev[k] : 128'd0);
        chk($sformatf("%s.alert", tag), 128'(alert_mod12), 128'(al));
    endtask

    task automatic set_all(input int a1r, a1q, a2r, a2q, s1r, s1q, s2r, s2q);
        din_R_add_1 = {DEPTH{15'(a1r)}};
        din_Q_add_1 = {DEPTH{15'(a1q)}};
        din_R_add_2 = {DEPTH{15'(a2r)}};
        din_Q_add_2 = {DEPTH{15'(a2q)}};
        din_R_sub_1 = {DEPTH{15'(s1r)}};
        din_Q_sub_1 = {DEPTH{15'(s1q)}};
        din_R_sub_2 = {DEPTH{15'(s2r)}};
        din_Q_sub_2 = {DEPTH{15'(s2q)}};
    endtask

    // Drives alert_mod11 from mask al for n cycles with inputs held. After the
    // edge ending cycle i, outputs reflect input cycle j=i-1; cycle j is in a
    // frame when it lies within 16 cycles of the latest alert at or before it.
    task automatic run_seq(input string tag, input int n, input logic [63:0] al);
        int last_al = -100;
        int j;
        for (int i = 0; i < n; i++) begin
            alert_mod11 = al[i];
            @(posedge clk);
            #1;
            j = i - 1;
            if (j >= 0 && al[j]) last_al = j;
            chk_outs($sformatf("%s@%0d", tag, j), (j >= 0) && (j - last_al < 16), (j >= 0) && al[j]);
        end
        alert_mod11 = 1'b0;
    endtask

    initial begin
        din_R_add_1 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_R_add_2 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_R_sub_1 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_R_sub_2 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_Q_add_1 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_Q_add_2 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_Q_sub_1 = 120'({$urandom, $urandom, $urandom, $urandom});
        din_Q_sub_2 = 120'({$urandom, $urandom, $urandom, $urandom});
        alert_mod11 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("in_reset", 1'b0, 1'b0);
        alert_mod11 = 1'b0;
        rstn = 1'b1;
        run_seq("post_reset", 6, 64'd0);

        set_all(100, 100, 30, 30, 50, 20, 10, 5);
        ev = '{rep(130), rep(70), rep(60), rep(15), rep(130), rep(70), rep(25), rep(-40)};
        run_seq("single", 22, 64'd1);

        set_all(16383, -16384, 16383, -16384, -16384, 0, 0, 0);
        ev = '{rep(32766), rep(0), rep(-16384), rep(0), rep(-32768), rep(0), rep(0), rep(16384)};
        run_seq("extreme", 20, 64'd1);

        din_R_add_1 = '0;
        set_all(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) din_R_add_1[k] = 15'(3 * k);
        ev = '{128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0};
        for (int k = 0; k < DEPTH; k++) begin
            ev[0][16*k +: 16] = 16'(3 * k);
            ev[1][16*k +: 16] = 16'(3 * k);
        end
        run_seq("lanes", 20, 64'd1);

        set_all(100, 100, 30, 30, 50, 20, 10, 5);
        ev = '{rep(130), rep(70), rep(60), rep(15), rep(130), rep(70), rep(25), rep(-40)};
        run_seq("b2b", 44, (64'd1 << 0) | (64'd1 << 16) | (64'd1 << 24));

        run_seq("pre_abort", 5, 64'd1);
        rstn = 1'b0;
        #1;
        chk_outs("abort", 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        run_seq("after_abort", 20, 64'd0);
        run_seq("restart", 20, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/mod1_2.md
Name: mod1_2

Overview:
- Third pipelined radix-2 stage of the parallel FFT datapath. Sits directly downstream of mod1_1 and consumes its 4x8-lane R/Q outputs and its alert_mod11 pulse.
- Per cycle, forms distance-8 butterflies within the add group (add_1 vs add_2) and within the sub group (sub_1 vs sub_2).
- Applies a trivial -j twiddle to the sub-group difference and registers the results.
- Emits alert_mod12 to the next stage, aligned with the first valid output.

Parameters:
- DIN_WIDTH, 15, input sample width, signed <7.6>
- DOUT_WIDTH, 16, output sample width, signed <8.6>; must equal DIN_WIDTH+1
- DEPTH, 8, lanes per group
- FRAME_LEN, 16, valid input cycles per frame

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- alert_mod11  in  1  single-cycle pulse, high in the cycle the first valid input set is present
- din_R_add_1 / din_R_add_2 / din_R_sub_1 / din_R_sub_2  in  signed DIN_WIDTH x DEPTH each  real inputs from mod1_1
- din_Q_add_1 / din_Q_add_2 / din_Q_sub_1 / din_Q_sub_2  in  signed DIN_WIDTH x DEPTH each  imaginary inputs from mod1_1
- dout_R_aa / dout_R_as / dout_R_sa / dout_R_ss  out  signed DOUT_WIDTH x DEPTH each  real outputs
- dout_Q_aa / dout_Q_as / dout_Q_sa / dout_Q_ss  out  signed DOUT_WIDTH x DEPTH each  imaginary outputs
- alert_mod12  out  1  single-cycle pulse, high with the first valid output set

Behaviour:
- Reset: async on rstn low. All dout_* = 0, alert_mod12 = 0, counter = 0, FSM = IDLE, pipeline registers = 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when alert_mod11 = 1; cnt loads 0 in that cycle.
  - RUN: cnt increments each cycle. RUN -> IDLE when cnt = FRAME_LEN-1 and alert_mod11 = 0.
  - alert_mod11 = 1 while in RUN (including on the last cycle) restarts the frame: cnt = 0, stay in RUN. The partial frame already in flight drains normally.
- Input capture: inputs are sampled only in cycles where the frame is active (alert_mod11 = 1, or RUN with cnt < FRAME_LEN). Otherwise stage-1 registers load 0. There are exactly FRAME_LEN active input cycles per frame.
- Stage 1 (registered, cycle t+1). Per lane k, sign-extend to DOUT_WIDTH:
  - aa = add_1[k] + add_2[k]
  - as = add_1[k] - add_2[k]
  - sa = sub_1[k] + sub_2[k]
  - d = sub_1[k] - sub_2[k]
  - Applied separately to R and Q. No overflow is possible at +1 bit; no saturation.
- Stage 2 (registered, cycle t+2):
  - aa, as, sa pass unchanged.
  - ss = d * (-j): dout_R_ss = d_Q, dout_Q_ss = -d_R.
  - Negation is computed at DOUT_WIDTH. d_R = -2^14 must yield +2^14, which is representable in 16 bits.
- Latency: 2 cycles, input to output.
- A valid-tag bit travels with the data. alert_mod12 = 1 at t+2 for the t cycle in which alert_mod11 was high, and only then.
- Outputs during non-active cycles are 0 after the pipeline drains.
- Reset mid-frame: everything clears immediately. No alert_mod12 is produced for the aborted frame.
- Lane order is preserved: lane k in maps to lane k out.

Test Plan:
- Reset: hold rstn = 0 with random inputs -> all outputs 0, alert_mod12 = 0. Release, no alert -> outputs stay 0.
- Single frame: alert_mod11 pulse with add_1 = 100, add_2 = 30, sub_1 = R 50 / Q 20, sub_2 = R 10 / Q 5 on all lanes, held 16 cycles.
  - alert_mod12 is high exactly 2 cycles after alert_mod11.
  - For 16 cycles: R_aa = 130, R_as = 70, R_sa = 60, R_ss = 15, Q_ss = -40.
  - Zeros afterwards.
- Extremes: add_1 = add_2 = 16383 -> aa = 32766. sub_1 R = -16384, sub_2 R = 0 -> Q_ss = +16384, no wrap.
- Lane independence: lane k input = k*3 on add_1, 0 elsewhere -> aa[k] = as[k] = 3k, all other groups 0.
- Back-to-back frames: second alert_mod11 at cycle 16 (immediately after the first frame) and again mid-frame at cycle 8 of a frame.
  - Counter restarts each time; each alert yields exactly one alert_mod12, 2 cycles later.
  - Data stays continuous, with no dropped cycles.
- Mid-frame reset: assert rstn = 0 at cycle 5 of a frame -> outputs 0 next edge, FSM IDLE. No alert_mod12 until a new alert_mod11 arrives.
